// File: rtl/alu_word_sequencer_if.sv
// alu_word_sequencer_if: word request/response handshake between a requester and the sequencer.
interface alu_word_sequencer_if #(parameter int BYTES = 2);
    localparam int W = 8 * BYTES;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_carry;
    logic         rsp_zero;
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero
    );
endinterface

// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: runs word ADD/AND/OR/XOR on the shared 8-bit ALU, one byte per ALU op, LSB first.
module alu_word_sequencer #(
    parameter int BYTES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_word_sequencer_if.slave  bus,
    output logic                 busy,
    output logic                 alu_enable,
    output logic [2:0]           alu_op,
    output logic [7:0]           alu_in_a,
    output logic [7:0]           alu_in_b,
    input  logic [7:0]           alu_out,
    input  logic                 alu_flag_carry
);
    localparam int IW = BYTES > 1 ? $clog2(BYTES) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
    state_t                   state;
    logic [IW-1:0]            idx;
    logic [IW-1:0]            nxt;
    logic [BYTES-1:0][7:0]    a_q;
    logic [BYTES-1:0][7:0]    b_q;
    logic [BYTES-1:0][7:0]    res_nx;
    logic [1:0]               op_q;
    logic                     last;
    // Word ADD starts with plain ADD so a carry left over from an earlier op never enters byte 0.
    function automatic logic [2:0] op_code(input logic [1:0] op, input logic first);
        return op == 2'b00 ? (first ? 3'b000 : 3'b111) : {1'b1, op - 2'b01};
    endfunction
    assign bus.req_ready = state == IDLE;
    assign busy          = state != IDLE;
    assign last          = idx == IW'(BYTES - 1);
    assign nxt           = idx + IW'(1);
    always_comb begin
        res_nx      = bus.rsp_result;
        res_nx[idx] = alu_out;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            idx            <= '0;
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_carry  <= 1'b0;
            bus.rsp_zero   <= 1'b0;
            alu_enable     <= 1'b0;
            alu_op         <= 3'b000;
            alu_in_a       <= '0;
            alu_in_b       <= '0;
        end else begin
            alu_enable <= 1'b0;
            alu_op     <= 3'b000;
            alu_in_a   <= '0;
            alu_in_b   <= '0;
            case (state)
                IDLE: if (bus.req_valid) begin
                    a_q            <= bus.req_a;
                    b_q            <= bus.req_b;
                    op_q           <= bus.req_op;
                    bus.rsp_result <= '0;
                    idx            <= '0;
                    alu_enable     <= 1'b1;
                    alu_op         <= op_code(bus.req_op, 1'b1);
                    alu_in_a       <= bus.req_a[7:0];
                    alu_in_b       <= bus.req_b[7:0];
                    state          <= ISSUE;
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    bus.rsp_result <= res_nx;
                    if (last) begin
                        bus.rsp_carry <= op_q == 2'b00 && alu_flag_carry;
                        bus.rsp_zero  <= res_nx == '0;
                        bus.rsp_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        idx        <= nxt;
                        alu_enable <= 1'b1;
                        alu_op     <= op_code(op_q, 1'b0);
                        alu_in_a   <= a_q[nxt];
                        alu_in_b   <= b_q[nxt];
                        state      <= ISSUE;
                    end
                end
                DONE: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_word_sequencer.sv
// tb_alu_word_sequencer: directed checks of 2-byte and 4-byte sequencers driving a behavioural 8-bit ALU.
module tb_alu_word_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  alu_word_sequencer_if #(.BYTES(2)) i2 ();
  alu_word_sequencer_if #(.BYTES(4)) i4 ();
  logic       busy2, en2, c2, busy4, en4, c4;
  logic [2:0] op2, op4;
  logic [7:0] ia2, ib2, o2, ia4, ib4, o4;
  alu_word_sequencer #(.BYTES(2)) d2 (
    .clk(clk), .reset(reset), .bus(i2), .busy(busy2), .alu_enable(en2), .alu_op(op2),
    .alu_in_a(ia2), .alu_in_b(ib2), .alu_out(o2), .alu_flag_carry(c2)
  );
  alu_word_sequencer #(.BYTES(4)) d4 (
    .clk(clk), .reset(reset), .bus(i4), .busy(busy4), .alu_enable(en4), .alu_op(op4),
    .alu_in_a(ia4), .alu_in_b(ib4), .alu_out(o4), .alu_flag_carry(c4)
  );
  function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a, b, input logic c);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b111:  return {1'b0, a} + {1'b0, b} + {8'h00, c};
      3'b100:  return {c, a & b};
      3'b101:  return {c, a | b};
      3'b110:  return {c, a ^ b};
      default: return {c, a};
    endcase
  endfunction
  initial begin
    o2 = 8'h00; c2 = 1'b0; o4 = 8'h00; c4 = 1'b0;
  end
  always @(posedge clk) if (en2) {c2, o2} <= alu_fn(op2, ia2, ib2, c2);
  always @(posedge clk) if (en4) {c4, o4} <= alu_fn(op4, ia4, ib4, c4);
  bit          wide = 1'b0;
  logic        s_rv, s_c, s_z, s_busy, s_en, s_ready;
  logic [2:0]  s_op;
  logic [31:0] s_res;
  always_comb begin
    s_rv    = wide ? i4.rsp_valid : i2.rsp_valid;
    s_c     = wide ? i4.rsp_carry : i2.rsp_carry;
    s_z     = wide ? i4.rsp_zero  : i2.rsp_zero;
    s_res   = wide ? i4.rsp_result : {16'h0000, i2.rsp_result};
    s_busy  = wide ? busy4 : busy2;
    s_en    = wide ? en4 : en2;
    s_op    = wide ? op4 : op2;
    s_ready = wide ? i4.req_ready : i2.req_ready;
  end
  task automatic run(input bit w, input logic [1:0] op, input logic [31:0] a, b, ex_r,
                     input logic ex_c, ex_z, input logic [2:0] op0, op1, input int hold, input string tag);
    int nb = w ? 4 : 2;
    bit early = 1'b0;
    bit stable = 1'b1;
    logic [31:0] held;
    wide = w;
    @(negedge clk);
    if (w) begin
      i4.req_valid = 1'b1; i4.req_op = op; i4.req_a = a; i4.req_b = b;
    end else begin
      i2.req_valid = 1'b1; i2.req_op = op; i2.req_a = a[15:0]; i2.req_b = b[15:0];
    end
    total++; if (s_ready === 1'b1) passed++; else $error("FAIL %s req_ready: got %0h", tag, s_ready);
    @(posedge clk); #1;
    i2.req_valid = 1'b0; i4.req_valid = 1'b0;
    total++; if ({s_en, s_op} === {1'b1, op0}) passed++; else $error("FAIL %s issue0 en/op: got %0h", tag, {s_en, s_op});
    for (int k = 1; k <= 2 * nb; k++) begin
      @(posedge clk); #1;
      if (k == 2) begin
        total++; if ({s_en, s_op} === {1'b1, op1}) passed++; else $error("FAIL %s issue1 en/op: got %0h", tag, {s_en, s_op});
      end
      if (k < 2 * nb && s_rv) early = 1'b1;
    end
    total++; if ({early, s_rv} === 2'b01) passed++; else $error("FAIL %s latency: got %0h", tag, {early, s_rv});
    total++; if (s_res === ex_r) passed++; else $error("FAIL %s result: got %0h expected %0h", tag, s_res, ex_r);
    total++; if (s_c === ex_c) passed++; else $error("FAIL %s carry: got %0h expected %0h", tag, s_c, ex_c);
    total++; if (s_z === ex_z) passed++; else $error("FAIL %s zero: got %0h expected %0h", tag, s_z, ex_z);
    held = s_res;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!s_rv || s_res !== held || s_ready || s_en || !s_busy) stable = 1'b0;
    end
    if (hold > 0) begin
      total++; if (stable === 1'b1) passed++; else $error("FAIL %s held stable", tag);
    end
    @(negedge clk);
    i2.rsp_ready = 1'b1; i4.rsp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if ({s_rv, s_busy, s_ready} === 3'b001) passed++; else $error("FAIL %s after handshake: got %0h", tag, {s_rv, s_busy, s_ready});
    total++; if (s_res === held) passed++; else $error("FAIL %s result kept: got %0h expected %0h", tag, s_res, held);
    i2.rsp_ready = 1'b0; i4.rsp_ready = 1'b0;
  endtask
  initial begin
    bit quiet = 1'b1;
    i2.req_valid = 1'b0; i2.req_op = 2'b00; i2.req_a = '0; i2.req_b = '0; i2.rsp_ready = 1'b0;
    i4.req_valid = 1'b0; i4.req_op = 2'b00; i4.req_a = '0; i4.req_b = '0; i4.rsp_ready = 1'b0;
    #1;
    total++; if ({i2.rsp_valid, i2.rsp_carry, i2.rsp_zero, busy2, en2, op2, ia2, ib2} === 24'h0) passed++; else $error("FAIL reset outputs");
    total++; if (i2.rsp_result === 16'h0000) passed++; else $error("FAIL reset result: got %0h", i2.rsp_result);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({i2.req_ready, i4.req_ready} === 2'b11) passed++; else $error("FAIL ready after reset");
    run(0, 2'b00, 32'h00FF, 32'h0001, 32'h0100, 1'b0, 1'b0, 3'b000, 3'b111, 0, "add 00ff+0001");
    run(0, 2'b00, 32'hFFFF, 32'h0001, 32'h0000, 1'b1, 1'b1, 3'b000, 3'b111, 0, "add ffff+0001");
    run(0, 2'b00, 32'h0001, 32'h0001, 32'h0002, 1'b0, 1'b0, 3'b000, 3'b111, 0, "add 0001+0001");
    run(0, 2'b11, 32'hA5A5, 32'hA5A5, 32'h0000, 1'b0, 1'b1, 3'b110, 3'b110, 0, "xor a5a5");
    run(0, 2'b10, 32'h1234, 32'h00F0, 32'h12F4, 1'b0, 1'b0, 3'b101, 3'b101, 5, "or backpressure");
    run(0, 2'b00, 32'h1111, 32'h2222, 32'h3333, 1'b0, 1'b0, 3'b000, 3'b111, 0, "add after release");
    wide = 1'b0;
    @(negedge clk);
    i2.req_valid = 1'b1; i2.req_op = 2'b00; i2.req_a = 16'h0F0F; i2.req_b = 16'h0101;
    @(posedge clk); #1;
    i2.req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (i2.rsp_result === 16'h0000) passed++; else $error("FAIL capture0 reached: got %0h", i2.rsp_result);
    reset = 1'b1;
    #1;
    total++; if ({i2.rsp_valid, i2.rsp_carry, i2.rsp_zero, busy2, en2, op2, ia2, ib2} === 24'h0) passed++; else $error("FAIL midop reset outputs");
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (i2.rsp_valid || busy2) quiet = 1'b0;
    end
    total++; if (quiet === 1'b1) passed++; else $error("FAIL no rsp after abort");
    total++; if (i2.rsp_result === 16'h0000) passed++; else $error("FAIL result cleared by reset: got %0h", i2.rsp_result);
    run(0, 2'b01, 32'hF0F0, 32'h3C3C, 32'h3030, 1'b0, 1'b0, 3'b100, 3'b100, 0, "and f0f0&3c3c");
    run(1, 2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 3'b000, 3'b111, 0, "add4 ffffffff+1");
    run(1, 2'b10, 32'h12000034, 32'h00560000, 32'h12560034, 1'b0, 1'b0, 3'b101, 3'b101, 0, "or4");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_word_sequencer.md
Name: alu_word_sequencer

Overview:
- Runs multi-byte (word) arithmetic and logic operations on the shared 8-bit ALU, one byte per ALU operation, least-significant byte first.
- Sits between the control unit (or any word-level requester) and the ALU. It owns the ALU's enable, op and operand inputs for the whole duration of an operation.
- Uses the ALU's ADD/ADC carry chain for word addition and computes the word-level zero flag itself.

Parameters:
- BYTES, 2, number of bytes per word; legal range 1..4; word width W = 8*BYTES.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_op  input  2  00 ADD, 01 AND, 10 OR, 11 XOR
- req_a  input  W  operand A
- req_b  input  W  operand B
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_result  output  W  word result
- rsp_carry  output  1  carry out of MSB (ADD only, else 0)
- rsp_zero  output  1  1 when rsp_result == 0
- busy  output  1  high in every state except IDLE
- alu_enable  output  1  to ALU enable
- alu_op  output  3  to ALU op (000 ADD, 111 ADC, 100 AND, 101 OR, 110 XOR)
- alu_in_a  output  8  to ALU in_a
- alu_in_b  output  8  to ALU in_b
- alu_out  input  8  from ALU out (registered, valid 1 cycle after enable)
- alu_flag_carry  input  1  from ALU flag_carry (registered with alu_out)

Behaviour:
- Reset (async): state=IDLE, byte index=0, operand/result registers=0, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_zero=0, busy=0, alu_enable=0, alu_op=000, alu_in_a=0, alu_in_b=0. req_ready=1 once reset deasserts.
- States: IDLE, ISSUE, CAPTURE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_a, req_b and req_op; clear result; set index=0; go to ISSUE.
- ISSUE:
  - alu_enable=1, alu_in_a = A byte[index], alu_in_b = B byte[index].
  - alu_op for ADD: ADD (000) at index 0, ADC (111) at index>0. This guarantees that no stale ALU carry enters byte 0.
  - alu_op for logic ops: AND/OR/XOR at every index.
  - Next state: CAPTURE.
- CAPTURE:
  - alu_enable=0; store alu_out into result byte[index].
  - If index==BYTES-1: register carry = (op==ADD) ? alu_flag_carry : 0; go to DONE.
  - Else: index++ and go back to ISSUE.
- DONE:
  - rsp_valid=1; rsp_result, rsp_carry and rsp_zero are held stable until rsp_valid&&rsp_ready.
  - On that handshake go to IDLE, deassert rsp_valid in the following cycle, and leave rsp_* values unchanged.
- ALU outputs outside ISSUE: alu_enable=0, alu_op=000, alu_in_a=alu_in_b=0.
- Latency: accept at cycle T; byte k issued at T+1+2k and captured at T+2+2k; rsp_valid first high at T+2*BYTES+1. Throughput is one operation per 2*BYTES+2 cycles when rsp_ready is held high.
- rsp_zero = (full registered W-bit result == 0), computed by the sequencer. The ALU flag_zero lags by one operation and is deliberately not used.
- Carry chain: ADC relies on the ALU's carry register being unchanged between bytes. The sequencer is the sole ALU driver while busy, so no other agent may enable the ALU in that window.
- Requests that arrive while busy are not accepted (req_ready=0); the requester holds them.
- Reset mid-operation: the block returns to IDLE immediately and drops any partial result. No rsp_valid is produced for the aborted request.
- BYTES=1: single ISSUE/CAPTURE pair; ADD uses op 000 only.

Test Plan:
- BYTES=2, ADD 0x00FF+0x0001 -> rsp_result=0x0100, carry=0, zero=0; rsp_valid at T+5; alu_op sequence 000 then 111.
- BYTES=2, ADD 0xFFFF+0x0001 -> result=0x0000, carry=1, zero=1.
- Carry isolation:
  - Step 1: ADD 0xFFFF+0x0001, leaving ALU carry=1.
  - Step 2: ADD 0x0001+0x0001 -> result=0x0002, carry=0.
  - Step 3: XOR 0xA5A5^0xA5A5 -> result=0x0000, carry=0, zero=1.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_* stable, req_ready=0, alu_enable=0; release -> IDLE one cycle later, next request accepted.
- Reset asserted at the CAPTURE of byte 0 of an ADD -> all outputs at reset values, no rsp_valid; a new AND 0xF0F0&0x3C3C after reset -> 0x3030.
- BYTES=4, ADD 0xFFFFFFFF+0x00000001 -> 0x00000000, carry=1, zero=1, rsp_valid at T+9; OR 0x12000034|0x00560000 -> 0x12560034, carry=0.
